// File: rtl/fetch_controller.sv
// fetch_controller: loads a program into instruction memory, then fetches it sequentially
// with stall, branch redirect and halt detection.
module fetch_controller #(
  parameter int          INSTR_MEM_SIZE = 1024,
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD      = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_start,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  input  logic        start,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        halted,
  output logic        fetch_error
);
  typedef enum logic [1:0] {IDLE, LOAD, FETCH, HALT} state_t;
  localparam logic [31:0] MEM_BYTES = 32'(INSTR_MEM_SIZE * 4);
  localparam logic [31:0] LAST_ADDR = 32'(INSTR_MEM_SIZE * 4 - 4);
  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ptr;
  logic        r_end;
  logic        w_beat;
  logic        w_tgt_ok;
  assign load_ready  = r_state == LOAD;
  assign w_beat      = load_ready & load_valid;
  assign imem_we     = w_beat;
  assign imem_waddr  = r_ptr;
  assign imem_wdata  = load_data;
  assign imem_addr   = r_pc;
  assign halted      = r_state == HALT;
  assign w_tgt_ok    = branch_target[1:0] == 2'b00 && branch_target < MEM_BYTES;
  // r_end marks that the last memory word was delivered, so the next normal cycle halts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      r_ptr       <= '0;
      r_end       <= 1'b0;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      instr_pc    <= '0;
      fetch_error <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load_start) begin
            r_state <= LOAD;
            r_ptr   <= '0;
          end else if (start) begin
            r_state <= FETCH;
            r_pc    <= RESET_PC;
            r_end   <= 1'b0;
          end
        end
        LOAD: begin
          if (w_beat) begin
            r_ptr <= r_ptr + 32'd4;
            if (load_last || r_ptr == LAST_ADDR) r_state <= IDLE;
          end
        end
        FETCH: begin
          if (branch_taken) begin
            instr_valid <= 1'b0;
            r_end       <= 1'b0;
            if (w_tgt_ok) r_pc <= branch_target;
            else begin
              r_state     <= HALT;
              fetch_error <= 1'b1;
            end
          end else if (!stall) begin
            if (r_end || imem_instr == HALT_WORD) begin
              r_state     <= HALT;
              instr_valid <= 1'b0;
            end else begin
              instr_out   <= imem_instr;
              instr_pc    <= r_pc;
              instr_valid <= 1'b1;
              r_end       <= r_pc == LAST_ADDR;
              if (r_pc != LAST_ADDR) r_pc <= r_pc + 32'd4;
            end
          end
        end
        HALT: begin
          if (load_start) begin
            r_state <= LOAD;
            r_ptr   <= '0;
          end else if (start) begin
            r_state     <= FETCH;
            r_pc        <= RESET_PC;
            r_end       <= 1'b0;
            fetch_error <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: random + directed stimulus against a behavioural fetch model,
// plus a 4-word instance for the end-of-memory boundary.
module tb_fetch_controller;
  localparam int          N    = 32;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  typedef enum {M_IDLE, M_LOAD, M_FETCH, M_HALT} mode_t;
  logic        clk, rst_n;
  logic        load_start, load_valid, load_last, start, stall, branch_taken;
  logic [31:0] load_data, branch_target;
  logic        load_ready, imem_we, instr_valid, halted, fetch_error;
  logic [31:0] imem_waddr, imem_wdata, imem_addr, imem_instr, instr_out, instr_pc;
  logic        s_ready, s_we, s_valid, s_halted, s_err;
  logic [31:0] s_waddr, s_wdata, s_addr, s_instr, s_out, s_pc;
  logic [31:0] mem [N];
  logic [31:0] s_mem [4];
  int checks = 0, failures = 0;
  mode_t       m_mode;
  logic [31:0] m_pc, m_ptr, m_out, m_ipc;
  logic        m_v, m_err;
  logic [31:0] m_mem [N];

  fetch_controller #(.INSTR_MEM_SIZE(N)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .start(start), .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_instr(imem_instr), .instr_valid(instr_valid),
    .instr_out(instr_out), .instr_pc(instr_pc), .halted(halted), .fetch_error(fetch_error));

  fetch_controller #(.INSTR_MEM_SIZE(4)) u_small (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(s_ready),
    .imem_we(s_we), .imem_waddr(s_waddr), .imem_wdata(s_wdata),
    .start(start), .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(s_addr), .imem_instr(s_instr), .instr_valid(s_valid),
    .instr_out(s_out), .instr_pc(s_pc), .halted(s_halted), .fetch_error(s_err));

  assign imem_instr = mem[imem_addr[6:2]];
  assign s_instr    = s_mem[s_addr[3:2]];
  initial begin
    for (int i = 0; i < N; i++) begin mem[i] = 0; m_mem[i] = 0; end
    for (int i = 0; i < 4; i++) s_mem[i] = 0;
  end
  always @(posedge clk) if (imem_we) mem[imem_waddr[6:2]] <= imem_wdata;
  always @(posedge clk) if (s_we) s_mem[s_waddr[3:2]] <= s_wdata;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // Behavioural model: program image, fetch pointer and delivered-instruction register
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_pc = 0; m_ptr = 0; m_v = 0; m_out = 0; m_ipc = 0; m_err = 0;
    end else begin
      case (m_mode)
        M_IDLE:
          if (load_start) begin m_mode = M_LOAD; m_ptr = 0; end
          else if (start) begin m_mode = M_FETCH; m_pc = 0; end
        M_LOAD:
          if (load_valid) begin
            m_mem[m_ptr / 4] = load_data;
            if (load_last || m_ptr / 4 == N - 1) m_mode = M_IDLE;
            m_ptr = m_ptr + 4;
          end
        M_FETCH:
          if (branch_taken) begin
            m_v = 0;
            if (branch_target % 4 == 0 && branch_target < N * 4) m_pc = branch_target;
            else begin m_mode = M_HALT; m_err = 1; end
          end else if (!stall) begin
            if ((m_v && m_ipc == N * 4 - 4 && m_pc == N * 4 - 4) || m_mem[m_pc / 4] == HALT) begin
              m_mode = M_HALT; m_v = 0;
            end else begin
              m_out = m_mem[m_pc / 4]; m_ipc = m_pc; m_v = 1;
              if (m_pc < N * 4 - 4) m_pc = m_pc + 4;
            end
          end
        M_HALT:
          if (load_start) begin m_mode = M_LOAD; m_ptr = 0; end
          else if (start) begin m_mode = M_FETCH; m_pc = 0; m_err = 0; end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("load_ready", 32'(load_ready), 32'(m_mode == M_LOAD));
    chk("imem_we", 32'(imem_we), 32'(m_mode == M_LOAD && load_valid));
    if (m_mode == M_LOAD && load_valid) begin
      chk("imem_waddr", imem_waddr, m_ptr);
      chk("imem_wdata", imem_wdata, load_data);
    end
    chk("imem_addr", imem_addr, m_pc);
    chk("halted", 32'(halted), 32'(m_mode == M_HALT));
    chk("instr_valid", 32'(instr_valid), 32'(m_v));
    chk("fetch_error", 32'(fetch_error), 32'(m_err));
    if (m_v || !rst_n) begin
      chk("instr_out", instr_out, m_out);
      chk("instr_pc", instr_pc, m_ipc);
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic l, input logic [31:0] a);
    load_valid = 1; load_data = d; load_last = l;
    #1;
    chk("beat_ready", 32'(load_ready), 1);
    chk("beat_we", 32'(imem_we), 1);
    chk("beat_waddr", imem_waddr, a);
    chk("beat_wdata", imem_wdata, d);
    cyc();
    load_valid = 0; load_last = 0;
  endtask

  initial begin
    rst_n = 0; load_start = 0; load_valid = 0; load_last = 0; load_data = 0;
    start = 0; stall = 0; branch_taken = 0; branch_target = 0;
    repeat (3) cyc();
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_ready", 32'(load_ready), 0);
    chk("rst_addr", imem_addr, 0);
    rst_n = 1;
    cyc();
    // three-word load
    load_start = 1; cyc(); load_start = 0;
    beat(32'h11, 0, 0); beat(32'h22, 0, 4); beat(32'h33, 1, 8);
    load_valid = 1; #1;
    chk("load_done_ready", 32'(load_ready), 0);
    chk("load_done_we", 32'(imem_we), 0);
    load_valid = 0;
    // fetch until halt word
    load_start = 1; cyc(); load_start = 0;
    beat(32'h11, 0, 0); beat(32'h22, 0, 4); beat(HALT, 1, 8);
    start = 1; cyc(); start = 0;
    chk("f0_valid", 32'(instr_valid), 0);
    cyc();
    chk("f1_valid", 32'(instr_valid), 1); chk("f1_out", instr_out, 32'h11); chk("f1_pc", instr_pc, 0);
    cyc();
    chk("f2_valid", 32'(instr_valid), 1); chk("f2_out", instr_out, 32'h22); chk("f2_pc", instr_pc, 4);
    cyc();
    chk("f3_halted", 32'(halted), 1); chk("f3_valid", 32'(instr_valid), 0); chk("f3_addr", imem_addr, 8);
    // branch beats stall
    load_start = 1; cyc(); load_start = 0;
    for (int i = 0; i < 20; i++) beat(32'h1000 + 32'(i), i == 19, 32'(i * 4));
    start = 1; cyc(); start = 0;
    cyc();
    stall = 1; branch_taken = 1; branch_target = 32'h40; cyc();
    stall = 0; branch_taken = 0;
    chk("br_addr", imem_addr, 32'h40); chk("br_valid", 32'(instr_valid), 0);
    cyc();
    chk("br_deliver_valid", 32'(instr_valid), 1);
    chk("br_deliver_out", instr_out, 32'h1010); chk("br_deliver_pc", instr_pc, 32'h40);
    // misaligned redirect
    branch_taken = 1; branch_target = 32'h42; cyc(); branch_taken = 0;
    chk("bad_halted", 32'(halted), 1); chk("bad_err", 32'(fetch_error), 1);
    start = 1; cyc(); start = 0;
    chk("restart_halted", 32'(halted), 0); chk("restart_err", 32'(fetch_error), 0);
    chk("restart_addr", imem_addr, 0);
    // reset in the middle of a load
    branch_taken = 1; branch_target = 32'h43; cyc(); branch_taken = 0;
    load_start = 1; cyc(); load_start = 0;
    beat(32'hA0, 0, 0); beat(32'hA1, 0, 4);
    load_valid = 1; load_data = 32'hA2; #2;
    rst_n = 0; #1;
    chk("midrst_we", 32'(imem_we), 0); chk("midrst_ready", 32'(load_ready), 0);
    load_valid = 0;
    cyc(); cyc();
    rst_n = 1;
    load_start = 1; cyc(); load_start = 0;
    beat(32'hB0, 1, 0);
    // four-word memory runs off its end
    load_start = 1; cyc(); load_start = 0;
    for (int k = 0; k < 4; k++) beat(32'h501 + 32'(k), 0, 32'(k * 4));
    load_valid = 1; load_data = 32'h505; load_last = 1; #1;
    chk("small_full_ready", 32'(s_ready), 0); chk("small_full_we", 32'(s_we), 0);
    cyc(); load_valid = 0; load_last = 0;
    start = 1; cyc(); start = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("small_valid", 32'(s_valid), 1);
      chk("small_out", s_out, 32'h501 + 32'(k));
      chk("small_pc", s_pc, 32'(k * 4));
    end
    cyc();
    chk("small_halted", 32'(s_halted), 1); chk("small_addr", s_addr, 32'hC);
    chk("small_end_valid", 32'(s_valid), 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if ($urandom_range(199) == 0) begin
        rst_n = 0; cyc(); cyc(); rst_n = 1;
      end
      load_start = $urandom_range(19) == 0;
      start = $urandom_range(9) == 0;
      load_valid = $urandom_range(9) < 7;
      load_last = $urandom_range(9) == 0;
      load_data = $urandom_range(9) == 0 ? HALT : $urandom;
      stall = $urandom_range(3) == 0;
      branch_taken = $urandom_range(11) == 0;
      case ($urandom_range(9))
        8: branch_target = 32'($urandom_range(127));
        9: branch_target = $urandom;
        default: branch_target = 32'($urandom_range(N - 1) * 4);
      endcase
    end
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
